// File: rtl/anffl_tex_addr_pipe.sv
// Two-stage texture address generator: request register (A) feeding an output register (B).
// Optional 2x2 bilinear footprint expansion is built only when ANFFL_TEX_BILINEAR_EN is defined.
module anffl_tex_addr_pipe #(
  parameter int ADDR_W  = 32,
  parameter int COORD_W = 16,
  parameter int TAG_W   = 8
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               inValid,
  output logic               inReady,
  input  logic [COORD_W-1:0] xPixel,
  input  logic [COORD_W-1:0] yPixel,
  input  logic [63:0]        texMeta,
  input  logic               clampMode,
  input  logic               bilinear,
  input  logic [TAG_W-1:0]   inTag,
  output logic               outValid,
  input  logic               outReady,
  output logic [ADDR_W-1:0]  addr,
  output logic [TAG_W-1:0]   outTag,
  output logic [1:0]         outSub,
  output logic               outLast,
  output logic               outErr
);

  typedef enum logic [1:0] {K_BMP, K_CMP, K_TIL, K_ERR} kind_e;

  logic               a_valid_q, a_valid_d;
  logic [COORD_W-1:0] x_q, y_q;
  logic [4:0]         fmt_q;
  logic [3:0]         we_q, he_q;
  logic [ADDR_W-1:0]  base_q;
  logic               clamp_q;
  logic [TAG_W-1:0]   tag_q;

  logic               out_valid_q;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [TAG_W-1:0]   out_tag_q;
  logic [1:0]         out_sub_q;
  logic               out_last_q, out_err_q, err_d;

  logic               b_adv, a_issue, a_last, accept, unused_ok;
  logic [1:0]         cur_sub;

`ifdef ANFFL_TEX_BILINEAR_EN
  logic               bil_q;
  logic [1:0]         sub_q, sub_d;
  assign unused_ok = ^texMeta[31:13];
`else
  assign unused_ok = ^{texMeta[31:13], bilinear};
`endif

  always_comb begin
    b_adv = !out_valid_q | outReady;
`ifdef ANFFL_TEX_BILINEAR_EN
    a_last  = !bil_q | (sub_q == 2'd3);
    cur_sub = sub_q;
`else
    a_last  = 1'b1;
    cur_sub = 2'd0;
`endif
    a_issue   = a_valid_q & b_adv;
    inReady   = rstN & (!a_valid_q | (a_last & b_adv));
    accept    = inValid & inReady;
    a_valid_d = accept | (a_valid_q & !(a_issue & a_last));
`ifdef ANFFL_TEX_BILINEAR_EN
    sub_d = sub_q;
    if (accept)
      sub_d = 2'd0;
    else if (a_issue && !a_last)
      sub_d = sub_q + 2'd1;
`endif
  end

  // Coordinate addressing: +1 is done one bit wider so repeat wraps and clamp saturates correctly.
  logic [COORD_W:0]  x_c, y_c, x_mask, y_mask, x_a, y_a;
  logic [ADDR_W-1:0] xe, ye, off, scaled, tile;
  kind_e             kind;
  logic [2:0]        sz_sh;
  logic              sz_x3;

  always_comb begin
    x_c    = {1'b0, x_q} + (COORD_W+1)'(cur_sub[0]);
    y_c    = {1'b0, y_q} + (COORD_W+1)'(cur_sub[1]);
    x_mask = ~({(COORD_W+1){1'b1}} << we_q);
    y_mask = ~({(COORD_W+1){1'b1}} << he_q);
    x_a    = clamp_q ? ((x_c > x_mask) ? x_mask : x_c) : (x_c & x_mask);
    y_a    = clamp_q ? ((y_c > y_mask) ? y_mask : y_c) : (y_c & y_mask);
    xe     = ADDR_W'(x_a);
    ye     = ADDR_W'(y_a);

    kind  = K_ERR;
    sz_sh = 3'd0;
    sz_x3 = 1'b0;
    case (fmt_q)
      5'b00000:                               begin kind = K_BMP; sz_sh = 3'd1; sz_x3 = 1'b1; end
      5'b00100:                               begin kind = K_BMP; sz_sh = 3'd2; end
      5'b00001, 5'b00101, 5'b01001, 5'b01101: begin kind = K_BMP; sz_sh = 3'd1; end
      5'b00010, 5'b01010, 5'b10010, 5'b10110: begin kind = K_CMP; sz_sh = 3'd3; end
      5'b00110:                               begin kind = K_CMP; sz_sh = 3'd4; end
      5'b00011:                               begin kind = K_TIL; sz_sh = 3'd1; sz_x3 = 1'b1; end
      5'b00111:                               begin kind = K_TIL; sz_sh = 3'd2; end
      5'b01011, 5'b01111, 5'b10111:           begin kind = K_TIL; sz_sh = 3'd1; end
      5'b10011:                               begin kind = K_TIL; sz_sh = 3'd0; end
      default: ;
    endcase
    if ((kind == K_CMP && we_q < 4'd2) || (kind == K_TIL && we_q < 4'd4))
      kind = K_ERR;

    tile = '0;
    case (kind)
      K_BMP:   off = (ye << we_q) + xe;
      K_CMP:   off = ((ye >> 2) << (we_q - 4'd2)) | (xe >> 2);
      K_TIL: begin
        tile = ((ye >> 4) << (we_q - 4'd4)) | (xe >> 4);
        off  = (tile << 8) + ADDR_W'({y_a[3:0], x_a[3:0]});
      end
      default: off = '0;
    endcase

    // Texel sizes are 1/2/4/8/16 (pure shift) or 3 (shift by one plus one copy).
    scaled = (off << sz_sh) + (sz_x3 ? off : '0);
    addr_d = base_q + scaled;
    err_d  = (kind == K_ERR);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      a_valid_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      fmt_q     <= '0;
      we_q      <= '0;
      he_q      <= '0;
      base_q    <= '0;
      clamp_q   <= 1'b0;
      tag_q     <= '0;
`ifdef ANFFL_TEX_BILINEAR_EN
      bil_q     <= 1'b0;
      sub_q     <= 2'd0;
`endif
    end else begin
      a_valid_q <= a_valid_d;
`ifdef ANFFL_TEX_BILINEAR_EN
      sub_q     <= sub_d;
`endif
      if (accept) begin
        x_q     <= xPixel;
        y_q     <= yPixel;
        fmt_q   <= texMeta[4:0];
        he_q    <= texMeta[8:5];
        we_q    <= texMeta[12:9];
        base_q  <= ADDR_W'(texMeta[63:32]);
        clamp_q <= clampMode;
        tag_q   <= inTag;
`ifdef ANFFL_TEX_BILINEAR_EN
        bil_q   <= bilinear;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      out_valid_q <= 1'b0;
      addr_q      <= '0;
      out_tag_q   <= '0;
      out_sub_q   <= 2'd0;
      out_last_q  <= 1'b0;
      out_err_q   <= 1'b0;
    end else if (b_adv) begin
      out_valid_q <= a_valid_q;
      if (a_valid_q) begin
        addr_q     <= addr_d;
        out_tag_q  <= tag_q;
        out_sub_q  <= cur_sub;
        out_last_q <= a_last;
        out_err_q  <= err_d;
      end
    end
  end

  assign outValid = out_valid_q;
  assign addr     = addr_q;
  assign outTag   = out_tag_q;
  assign outSub   = out_sub_q;
  assign outLast  = out_last_q;
  assign outErr   = out_err_q;

endmodule

// File: tb/tb_anffl_tex_addr_pipe.sv
// Self-checking bench for anffl_tex_addr_pipe: directed cases plus a randomized stream
// scored against an arithmetic reference model.
module tb_anffl_tex_addr_pipe;

`ifdef ANFFL_TEX_BILINEAR_EN
  localparam bit BIL_EN = 1'b1;
`else
  localparam bit BIL_EN = 1'b0;
`endif

  logic        clk, rstN, inValid, inReady, clampMode, bilinear, outValid, outReady;
  logic [15:0] xPixel, yPixel;
  logic [63:0] texMeta;
  logic [7:0]  inTag, outTag;
  logic [31:0] addr;
  logic [1:0]  outSub;
  logic        outLast, outErr;

  anffl_tex_addr_pipe #(.ADDR_W(32), .COORD_W(16), .TAG_W(8)) dut (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady),
    .xPixel(xPixel), .yPixel(yPixel), .texMeta(texMeta), .clampMode(clampMode),
    .bilinear(bilinear), .inTag(inTag), .outValid(outValid), .outReady(outReady),
    .addr(addr), .outTag(outTag), .outSub(outSub), .outLast(outLast), .outErr(outErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  tag;
    logic [1:0]  sub;
    logic        last;
    logic        err;
  } ent_t;

  ent_t exp_q[$];
  ent_t got_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] mk(input logic [31:0] base, input int we, input int he,
                                     input logic [4:0] fmt);
    logic [3:0] w4, h4;
    w4 = 4'(we);
    h4 = 4'(he);
    return {base, 19'd0, w4, h4, fmt};
  endfunction

  function automatic longint unsigned coord(input longint unsigned c, input int e, input bit clamp);
    longint unsigned w;
    w = longint'(1) << e;
    if (clamp) return (c > w - 1) ? w - 1 : c;
    return c % w;
  endfunction

  // Reference: expected address list for one request, from the format table and plain arithmetic.
  task automatic push_model(input logic [15:0] x, input logic [15:0] y, input logic [63:0] meta,
                            input bit clamp, input bit bil, input logic [7:0] tag);
    int fmt, we, he, kind, bpu, n;
    longint unsigned cx, cy, w, off, a;
    ent_t e;
    fmt = int'(meta[4:0]); he = int'(meta[8:5]); we = int'(meta[12:9]);
    kind = 3; bpu = 0;
    case (fmt)
      5'b00000: begin kind = 0; bpu = 3; end
      5'b00100: begin kind = 0; bpu = 4; end
      5'b00001, 5'b00101, 5'b01001, 5'b01101: begin kind = 0; bpu = 2; end
      5'b00010, 5'b01010, 5'b10010, 5'b10110: begin kind = 1; bpu = 8; end
      5'b00110: begin kind = 1; bpu = 16; end
      5'b00011: begin kind = 2; bpu = 3; end
      5'b00111: begin kind = 2; bpu = 4; end
      5'b01011, 5'b01111, 5'b10111: begin kind = 2; bpu = 2; end
      5'b10011: begin kind = 2; bpu = 1; end
      default: kind = 3;
    endcase
    if (kind == 1 && we < 2) kind = 3;
    if (kind == 2 && we < 4) kind = 3;
    n = (BIL_EN && bil) ? 4 : 1;
    w = longint'(1) << we;
    for (int s = 0; s < n; s++) begin
      cx = coord(longint'(x) + longint'(s % 2), we, clamp);
      cy = coord(longint'(y) + longint'(s / 2), he, clamp);
      case (kind)
        0: off = cy * w + cx;
        1: off = (cy / 4) * (w / 4) + cx / 4;
        2: off = ((cy / 16) * (w / 16) + cx / 16) * 256 + (cy % 16) * 16 + cx % 16;
        default: off = 0;
      endcase
      a = longint'(meta[63:32]) + off * longint'(bpu);
      e.addr = a[31:0];
      e.tag  = tag;
      e.sub  = 2'(s);
      e.last = (s == n - 1);
      e.err  = (kind == 3);
      exp_q.push_back(e);
    end
  endtask

  // One clock: called just after a falling edge with inputs already driven.
  task automatic step();
    ent_t e, g;
    #1;
    chk("spurious_out", {63'd0, outValid && exp_q.size() == 0}, 64'd0);
    if (outValid && exp_q.size() > 0) begin
      e = exp_q[0];
      chk("addr", addr, e.addr);
      chk("tag", outTag, e.tag);
      chk("sub", outSub, e.sub);
      chk("last", outLast, e.last);
      chk("err", outErr, e.err);
    end
    last_acc = inValid & inReady;
    if (outValid && outReady) begin
      g = '{addr: addr, tag: outTag, sub: outSub, last: outLast, err: outErr};
      got_q.push_back(g);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (last_acc) push_model(xPixel, yPixel, texMeta, clampMode, bilinear, inTag);
    @(negedge clk);
  endtask

  task automatic set_req(input logic [15:0] x, input logic [15:0] y, input logic [63:0] meta,
                         input bit clamp, input bit bil, input logic [7:0] tag);
    xPixel = x; yPixel = y; texMeta = meta; clampMode = clamp; bilinear = bil; inTag = tag;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [63:0] meta,
                      input bit clamp, input bit bil, input logic [7:0] tag);
    bit ok;
    ok = 1'b0;
    set_req(x, y, meta, clamp, bil, tag);
    inValid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      step();
      ok = last_acc;
    end
    inValid = 1'b0;
    texMeta = 64'hFFFF_FFFF_FFFF_FFFF;
    chk("accept_timeout", {63'd0, ok}, 64'd1);
  endtask

  task automatic drain();
    outReady = 1'b1;
    for (int i = 0; i < 100 && (exp_q.size() > 0 || outValid); i++) step();
    chk("drain_timeout", exp_q.size(), 64'd0);
  endtask

  task automatic chk_got(input string tag, input int idx, input logic [31:0] a,
                         input logic [1:0] s, input logic last, input logic err);
    ent_t g;
    g = got_q[idx];
    chk({tag, "_addr"}, g.addr, a);
    chk({tag, "_sub"}, g.sub, s);
    chk({tag, "_last"}, g.last, last);
    chk({tag, "_err"}, g.err, err);
  endtask

  int          sent, tgt;
  bit          seen;
  logic [4:0]  fmts [12];
  logic [31:0] rep_exp [4];
  logic [31:0] clp_exp [4];

  initial begin
    fmts    = '{5'b00000, 5'b00100, 5'b01001, 5'b00010, 5'b00110, 5'b10110,
                5'b00011, 5'b00111, 5'b10111, 5'b10011, 5'b11111, 5'b01000};
    rep_exp = '{32'h1FE, 32'h000, 32'h3FE, 32'h200};
    clp_exp = '{32'h1FE, 32'h1FE, 32'h3FE, 32'h3FE};
    rstN = 1'b0; inValid = 1'b0; outReady = 1'b1;
    set_req(16'd0, 16'd0, 64'd0, 1'b0, 1'b0, 8'd0);
    #2;
    chk("rst_valid", outValid, 64'd0);
    chk("rst_addr", addr, 64'd0);
    chk("rst_tag", outTag, 64'd0);
    chk("rst_sub", outSub, 64'd0);
    chk("rst_last", outLast, 64'd0);
    chk("rst_err", outErr, 64'd0);
    chk("rst_inready", inReady, 64'd0);
    @(negedge clk); @(negedge clk);
    rstN = 1'b1;

    // RGBA_32 point request and its one-cycle latency
    got_q.delete();
    send(16'd5, 16'd2, mk(32'h1000_0000, 8, 8, 5'b00100), 1'b0, 1'b0, 8'h11);
    chk("latency_early", outValid, 64'd0);
    step();
    chk("latency_valid", outValid, 64'd1);
    drain();
    chk_got("rgba32", 0, 32'h1000_0814, 2'd0, 1'b1, 1'b0);

    // RGB_16 bilinear, repeat then clamp, at the right edge
    got_q.delete();
    send(16'd255, 16'd0, mk(32'h0, 8, 8, 5'b00001), 1'b0, 1'b1, 8'h22);
    drain();
    if (BIL_EN) begin
      for (int i = 0; i < 4; i++) chk_got("bil_rep", i, rep_exp[i], 2'(i), i == 3, 1'b0);
    end else begin
      chk_got("bil_rep", 0, rep_exp[0], 2'd0, 1'b1, 1'b0);
    end
    got_q.delete();
    send(16'd255, 16'd0, mk(32'h0, 8, 8, 5'b00001), 1'b1, 1'b1, 8'h23);
    drain();
    if (BIL_EN) begin
      for (int i = 0; i < 4; i++) chk_got("bil_clamp", i, clp_exp[i], 2'(i), i == 3, 1'b0);
    end else begin
      chk_got("bil_clamp", 0, clp_exp[0], 2'd0, 1'b1, 1'b0);
    end

    // Tiled, compressed and error formats
    got_q.delete();
    send(16'd17, 16'd33, mk(32'h0, 6, 6, 5'b10011), 1'b0, 1'b0, 8'h31);
    send(16'd9, 16'd6, mk(32'h0, 4, 4, 5'b00110), 1'b0, 1'b0, 8'h32);
    send(16'd9, 16'd6, mk(32'hABCD_0000, 4, 4, 5'b11111), 1'b0, 1'b0, 8'h33);
    send(16'd1, 16'd1, mk(32'h0000_4000, 1, 4, 5'b00010), 1'b0, 1'b0, 8'h34);
    send(16'd1, 16'd1, mk(32'h0000_5000, 3, 4, 5'b00111), 1'b0, 1'b0, 8'h35);
    drain();
    chk_got("tiled_r8", 0, 32'h911, 2'd0, 1'b1, 1'b0);
    chk_got("etc2_rgba", 1, 32'h60, 2'd0, 1'b1, 1'b0);
    chk_got("bad_fmt", 2, 32'hABCD_0000, 2'd0, 1'b1, 1'b1);
    chk_got("cmp_narrow", 3, 32'h0000_4000, 2'd0, 1'b1, 1'b1);
    chk_got("til_narrow", 4, 32'h0000_5000, 2'd0, 1'b1, 1'b1);

    // Back-to-back point stream with a 3-cycle output stall
    got_q.delete();
    sent = 0;
    for (int g = 0; g < 100 && sent < 6; g++) begin
      set_req(16'(sent * 7), 16'(sent), mk(32'h2000_0000, 5, 5, 5'b00100), 1'b0, 1'b0, 8'(8'h40 + sent));
      inValid = 1'b1;
      if (sent == 3 && outReady) begin
        outReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
          #1;
          chk("stall_inready", inReady, 64'd0);
          step();
        end
        outReady = 1'b1;
      end
      step();
      if (last_acc) sent++;
    end
    inValid = 1'b0;
    drain();
    chk("stream_count", got_q.size(), 64'd6);

    // Asynchronous reset in the middle of a footprint
    got_q.delete();
    tgt = BIL_EN ? 1 : 0;
    seen = 1'b0;
    set_req(16'd3, 16'd3, mk(32'h3000_0000, 6, 6, 5'b00100), 1'b0, 1'b1, 8'h55);
    inValid = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (last_acc) inValid = 1'b0;
      foreach (got_q[j]) if (got_q[j].sub == 2'(tgt)) seen = 1'b1;
    end
    inValid = 1'b0;
    chk("reset_target_seen", {63'd0, seen}, 64'd1);
    #2 rstN = 1'b0;
    #1;
    chk("mid_rst_valid", outValid, 64'd0);
    chk("mid_rst_addr", addr, 64'd0);
    chk("mid_rst_sub", outSub, 64'd0);
    chk("mid_rst_last", outLast, 64'd0);
    chk("mid_rst_inready", inReady, 64'd0);
    exp_q.delete();
    @(negedge clk); @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 4; i++) step();
    got_q.delete();
    send(16'd1, 16'd2, mk(32'h3000_0000, 6, 6, 5'b00100), 1'b0, 1'b1, 8'h56);
    drain();
    chk("post_rst_count", got_q.size(), BIL_EN ? 64'd4 : 64'd1);
    chk_got("post_rst", 0, 32'h3000_0000 + (2 * 64 + 1) * 4, 2'd0, !BIL_EN, 1'b0);

    // Randomized traffic against the reference model
    inValid = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (!inValid || last_acc) begin
        int we, he;
        we = $urandom_range(0, 15);
        he = $urandom_range(0, 15);
        set_req(($urandom_range(0, 3) == 0) ? 16'((1 << we) - 1) : 16'($urandom),
                ($urandom_range(0, 3) == 0) ? 16'((1 << he) - 1) : 16'($urandom),
                mk($urandom, we, he, fmts[$urandom_range(0, 11)]),
                1'($urandom), 1'($urandom), 8'($urandom));
        inValid = ($urandom_range(0, 3) != 0);
      end
      outReady = ($urandom_range(0, 3) != 0);
      step();
    end
    inValid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/anffl_tex_addr_pipe.md
# anffl_tex_addr_pipe

Pipelined, parametrised texture address generator for the Anf Floof texture unit. It accepts one texel-coordinate request per cycle over a valid/ready handshake and applies per-request repeat or clamp coordinate addressing. It then emits byte addresses for every supported bitmap, tiled and ETC2/EAC format, expanding a request into a 2x2 bilinear footprint when asked. It sits between the fragment texture-coordinate stage and the texture cache request port.

## Interface
- `ADDR_W`, 32: address width; base address field is `texMeta[63:32]`, zero-extended or truncated to `ADDR_W`.
- `COORD_W`, 16: width of `xPixel`/`yPixel`.
- `TAG_W`, 8: width of the opaque request tag.

- `clk`  in  1  clock.
- `rstN`  in  1  asynchronous, active-low reset.
- `inValid`  in  1  request present.
- `inReady`  out  1  request accepted when `inValid & inReady` at a rising edge.
- `xPixel`, `yPixel`  in  `COORD_W`  unsigned texel coordinates.
- `texMeta`  in  64  format `[4:0]`, heightExp `[8:5]`, widthExp `[12:9]`, base `[63:32]`.
- `clampMode`  in  1  0 = repeat (mask to size), 1 = clamp to `size-1`.
- `bilinear`  in  1  request a 2x2 footprint.
- `inTag`  in  `TAG_W`  returned unchanged with every address of the request.
- `outValid`  out  1  address present.
- `outReady`  in  1  consumer accepts when `outValid & outReady`.
- `addr`  out  `ADDR_W`  byte address.
- `outTag`  out  `TAG_W`  tag of the originating request.
- `outSub`  out  2  footprint index 0..3 (0 for point requests).
- `outLast`  out  1  last address of the request.
- `outErr`  out  1  unsupported format or size; `addr` = base.

## Operation
- Stage A holds the request register and a 2-bit sub counter. Stage B holds the output register.
- Footprint order:
  - 0: (x,y)
  - 1: (x+1,y)
  - 2: (x,y+1)
  - 3: (x+1,y+1)
- Point request = sub 0 only, with `outLast`=1.
- +1 is computed in `COORD_W+1` bits, then addressed:
  - W = 1<<widthExp, H = 1<<heightExp.
  - Repeat: keep the low widthExp/heightExp bits.
  - Clamp: min(c, W-1) or min(c, H-1).
  - Addressing is applied to the base coordinate too.
- Bitmap offset: p = (y<<widthExp)+x, in `ADDR_W` bits. Bytes per texel:
  - RGB_24 (00000): 3
  - RGBA_32 (00100): 4
  - 16/15-bit (00001, 00101, 01001, 01101): 2
- Compressed formats use 4x4 blocks: b = ((y>>2)<<(widthExp-2)) | (x>>2). Bytes per block:
  - RGB_ETC2 (00010), RGBA_ETC2_PUNCHTHROUGH (01010), R_EAC U/S (10010, 10110): 8
  - RGBA_ETC2 (00110): 16
- Tiled formats use 16x16 tiles:
  - t = ((y>>4)<<(widthExp-4)) | (x>>4).
  - p = t·256 + {y[3:0],x[3:0]}.
  - Bytes per texel: RGB24 (00011) 3, RGBA32 (00111) 4, RGB16/RGBA16/R16 (01011, 01111, 10111) 2, R8 (10011) 1.
- `addr` = base + offset·size, modulo 2^`ADDR_W`.
- `outErr`=1 and offset = 0 for any of:
  - any other format code;
  - compressed with widthExp<2;
  - tiled with widthExp<4.
  - Errored requests still emit their full footprint.

## Timing
- Stage B advances when `!outValid | outReady`. Stage A issues its current sub to B whenever B advances.
- `inReady` = (A empty) | (A issuing its last sub and B advancing). It is forced 0 while `rstN` is low. It is combinational from `outReady`.
- Latency: a request accepted at edge k produces its first address valid after edge k+1.
- Throughput:
  - Point requests: 1 per cycle.
  - Bilinear requests: 4 cycles each, back-to-back with no bubble.
- While `outValid & !outReady`, `addr`, `outTag`, `outSub`, `outLast` and `outErr` are held stable.
- Inputs are sampled only at acceptance. Later changes to `texMeta` do not affect in-flight addresses.
- Reset (async, any time, including mid-footprint):
  - Both stages are emptied, the sub counter is cleared and the partial footprint is dropped.
  - Reset values: `outValid`=0, `addr`=0, `outTag`=0, `outSub`=0, `outLast`=0, `outErr`=0.

## Configuration
- `ANFFL_TEX_BILINEAR_EN` defined: footprint expansion as specified.
- `ANFFL_TEX_BILINEAR_EN` undefined:
  - `bilinear` is ignored and the sub counter is not built.
  - Every request emits one address with `outSub`=0 and `outLast`=1.
  - `inReady` = A empty | B advancing.

## Test plan
- RGBA_32, base 0x1000_0000, widthExp 8, x=5, y=2, point -> one address 0x1000_0814 one cycle after acceptance, `outLast`=1.
- RGB_16, base 0, wE=hE=8, x=255, y=0, bilinear, repeat -> 0x1FE, 0x000, 0x3FE, 0x200 with subs 0..3; `outLast` only on sub 3.
- Same request with clamp -> 0x1FE, 0x1FE, 0x3FE, 0x3FE.
- R_8_TILED wE=6, x=17, y=33 -> 0x911. RGBA_ETC2 wE=4, x=9, y=6 -> 0x60. Format 11111 -> `addr`=base, `outErr`=1.
- Back-to-back point stream with `outReady` low 3 cycles mid-stream -> outputs held stable, no loss or duplication, `inReady` low while stalled.
- `rstN` pulsed low after sub 1 of a bilinear request -> `outValid`=0 immediately, remaining subs never appear, next request starts at sub 0.
